// File: rtl/vxc_mul3_sequencer_pkg.sv
// Shared definitions for the mul3 sequencer: FSM encoding and chunk geometry helpers.
// Chunk count and tail width are derived here so every file agrees on them.
package vxc_seq_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = S_IDLE,
        READ  = S_READ,
        DRAIN = S_DRAIN,
        DONE  = S_DONE
    } seq_state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    function automatic int num_chunks(input int num_eq, input int units);
        return (num_eq + units - 1) / units;
    endfunction

    function automatic int tail_lanes(input int num_eq, input int units);
        return num_eq % units;
    endfunction

    localparam int NUM_EQ_DEFAULT      = 19;
    localparam int NO_OF_UNITS_DEFAULT = 8;
    localparam int NUM_CHUNKS          = num_chunks(NUM_EQ_DEFAULT, NO_OF_UNITS_DEFAULT);
    localparam int TAIL                = tail_lanes(NUM_EQ_DEFAULT, NO_OF_UNITS_DEFAULT);

endpackage

// File: rtl/vxc_mul3_sequencer_if.sv
// Bundle of the operand-memory, datapath and result-memory signals around the sequencer.
// The sequencer drives through the master modport; memories and datapath sit on the slave side.
interface vxc_mul3_sequencer_if #(
    parameter int NO_OF_UNITS   = 8,
    parameter int ELEMENT_WIDTH = 64,
    parameter int ADDR_WIDTH    = 8
);

    localparam int CHUNK_W = NO_OF_UNITS * ELEMENT_WIDTH;

    logic                     rd_en;
    logic [ADDR_WIDTH-1:0]    rd_addr;
    logic [CHUNK_W-1:0]       rd_data_a;
    logic [CHUNK_W-1:0]       rd_data_b;

    logic [CHUNK_W-1:0]       dp_a;
    logic [CHUNK_W-1:0]       dp_b;
    logic [ELEMENT_WIDTH-1:0] dp_constant;
    logic                     dp_op;
    logic                     dp_valid_in;
    logic [CHUNK_W-1:0]       dp_result;

    logic                     wr_en;
    logic [ADDR_WIDTH-1:0]    wr_addr;
    logic [CHUNK_W-1:0]       wr_data;
    logic [NO_OF_UNITS-1:0]   wr_lane_en;

    modport master (
        output rd_en, rd_addr,
        input  rd_data_a, rd_data_b,
        output dp_a, dp_b, dp_constant, dp_op, dp_valid_in,
        input  dp_result,
        output wr_en, wr_addr, wr_data, wr_lane_en
    );

    modport slave (
        input  rd_en, rd_addr,
        output rd_data_a, rd_data_b,
        input  dp_a, dp_b, dp_constant, dp_op, dp_valid_in,
        output dp_result,
        input  wr_en, wr_addr, wr_data, wr_lane_en
    );

endinterface

// File: rtl/vxc_mul3_sequencer_delay_line.sv
// Fixed-depth shift register carrying {valid, chunk index} alongside the datapath pipeline.
// 'pending' flags any valid still in flight ahead of the output stage.
module vxc_seq_delay_line #(
    parameter int DEPTH      = 3,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  in_valid,
    input  logic [ADDR_WIDTH-1:0] in_index,
    output logic                  out_valid,
    output logic [ADDR_WIDTH-1:0] out_index,
    output logic                  pending
);

    logic [DEPTH-1:0]      valid_q;
    logic [DEPTH-1:0]      valid_d;
    logic [ADDR_WIDTH-1:0] index_q [DEPTH];
    logic [ADDR_WIDTH-1:0] index_d [DEPTH];

    always_comb begin
        valid_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            index_d[i] = '0;
        end
        valid_d[0] = in_valid;
        index_d[0] = in_index;
        for (int i = 1; i < DEPTH; i++) begin
            valid_d[i] = valid_q[i-1];
            index_d[i] = index_q[i-1];
        end
    end

    // The output stage is excluded so the drain check can retire on the last write cycle.
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            pending = pending | valid_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                index_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < DEPTH; i++) begin
                index_q[i] <= index_d[i];
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_index = index_q[DEPTH-1];

endmodule

// File: rtl/vxc_mul3_sequencer.sv
// Start/done sequencer that streams operand chunks through the a*constant+-b datapath
// and writes the aligned results back with per-lane enables.
module vxc_mul3_sequencer
    import vxc_seq_pkg::*;
#(
    parameter int NUM_EQ        = 19,
    parameter int NO_OF_UNITS   = 8,
    parameter int ELEMENT_WIDTH = 64,
    parameter int DP_LATENCY    = 3,
    parameter int ADDR_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     op,
    input  logic [ELEMENT_WIDTH-1:0] constant,
    input  logic [ADDR_WIDTH-1:0]    rd_base,
    input  logic [ADDR_WIDTH-1:0]    wr_base,
    output logic                     busy,
    output logic                     done,
    vxc_mul3_sequencer_if.master     bus
);

    localparam int CHUNK_W  = NO_OF_UNITS * ELEMENT_WIDTH;
    localparam int N_CHUNKS = num_chunks(NUM_EQ, NO_OF_UNITS);
    localparam int N_TAIL   = tail_lanes(NUM_EQ, NO_OF_UNITS);

    localparam logic [ADDR_WIDTH-1:0]  LAST_IDX  = ADDR_WIDTH'(N_CHUNKS - 1);
    localparam logic [NO_OF_UNITS-1:0] FULL_MASK = '1;
    localparam logic [NO_OF_UNITS-1:0] TAIL_MASK =
        (N_TAIL == 0) ? FULL_MASK : NO_OF_UNITS'((1 << N_TAIL) - 1);

    seq_state_e               state_q, state_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0]    rd_addr_q, rd_addr_d;
    logic [ADDR_WIDTH-1:0]    chunk_q, chunk_d;
    logic [ADDR_WIDTH-1:0]    wr_base_q, wr_base_d;
    logic                     op_q, op_d;
    logic [ELEMENT_WIDTH-1:0] constant_q, constant_d;
    logic [CHUNK_W-1:0]       dp_a_q, dp_a_d;
    logic [CHUNK_W-1:0]       dp_b_q, dp_b_d;
    logic                     dp_valid_q, dp_valid_d;
    logic [ADDR_WIDTH-1:0]    dp_idx_q, dp_idx_d;

    logic                     wr_valid;
    logic [ADDR_WIDTH-1:0]    wr_idx;
    logic                     pipe_pending;

    // Operand capture runs independently of the FSM: every read strobe lands in the operand stage next cycle.
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        rd_en_d    = rd_en_q;
        rd_addr_d  = rd_addr_q;
        chunk_d    = chunk_q;
        wr_base_d  = wr_base_q;
        op_d       = op_q;
        constant_d = constant_q;
        dp_a_d     = dp_a_q;
        dp_b_d     = dp_b_q;
        dp_idx_d   = dp_idx_q;
        dp_valid_d = rd_en_q;

        if (rd_en_q) begin
            dp_a_d   = bus.rd_data_a;
            dp_b_d   = bus.rd_data_b;
            dp_idx_d = chunk_q;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d       = op;
                    constant_d = constant;
                    wr_base_d  = wr_base;
                    rd_addr_d  = rd_base;
                    chunk_d    = '0;
                    rd_en_d    = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = READ;
                end
            end
            READ: begin
                if (chunk_q == LAST_IDX) begin
                    rd_en_d = 1'b0;
                    state_d = DRAIN;
                end else begin
                    chunk_d   = chunk_q + ADDR_WIDTH'(1);
                    rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
                end
            end
            DRAIN: begin
                if (!dp_valid_q && !pipe_pending) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            chunk_q    <= '0;
            wr_base_q  <= '0;
            op_q       <= 1'b0;
            constant_q <= '0;
            dp_a_q     <= '0;
            dp_b_q     <= '0;
            dp_valid_q <= 1'b0;
            dp_idx_q   <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            chunk_q    <= chunk_d;
            wr_base_q  <= wr_base_d;
            op_q       <= op_d;
            constant_q <= constant_d;
            dp_a_q     <= dp_a_d;
            dp_b_q     <= dp_b_d;
            dp_valid_q <= dp_valid_d;
            dp_idx_q   <= dp_idx_d;
        end
    end

    vxc_seq_delay_line #(
        .DEPTH      (DP_LATENCY),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_delay_line (
        .clk       (clk),
        .clear     (reset),
        .in_valid  (dp_valid_q),
        .in_index  (dp_idx_q),
        .out_valid (wr_valid),
        .out_index (wr_idx),
        .pending   (pipe_pending)
    );

    assign busy            = busy_q;
    assign done            = done_q;
    assign bus.rd_en       = rd_en_q;
    assign bus.rd_addr     = rd_addr_q;
    assign bus.dp_a        = dp_a_q;
    assign bus.dp_b        = dp_b_q;
    assign bus.dp_constant = constant_q;
    assign bus.dp_op       = op_q;
    assign bus.dp_valid_in = dp_valid_q;

    // Only the final chunk can be partial; lanes beyond the tail must not be written.
    assign bus.wr_en      = wr_valid;
    assign bus.wr_addr    = wr_base_q + wr_idx;
    assign bus.wr_data    = bus.dp_result;
    assign bus.wr_lane_en = wr_valid ? ((wr_idx == LAST_IDX) ? TAIL_MASK : FULL_MASK) : '0;

endmodule

// File: tb/tb_vxc_mul3_sequencer.sv
// Self-checking bench for vxc_mul3_sequencer: cycle-exact vector table plus a write scoreboard.
// A second instance with NUM_EQ=16 covers the no-tail lane mask.
module tb_vxc_mul3_sequencer;

    localparam int NU  = 8;
    localparam int EW  = 64;
    localparam int AW  = 8;
    localparam int DPL = 3;
    localparam int CW  = NU * EW;
    localparam int TB_CHUNKS = 3;
    localparam logic [7:0] TB_LAST_LANE = 8'h07;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          op;
    logic [EW-1:0] constant;
    logic [AW-1:0] rd_base;
    logic [AW-1:0] wr_base;
    logic          busy;
    logic          done;

    logic          start16;
    logic          busy16;
    logic          done16;

    int checks = 0;
    int errors = 0;

    logic [CW-1:0] mem_a [256];
    logic [CW-1:0] mem_b [256];
    logic [CW-1:0] dp_pipe [DPL];

    always #5 clk = ~clk;

    vxc_mul3_sequencer_if #(.NO_OF_UNITS(NU), .ELEMENT_WIDTH(EW), .ADDR_WIDTH(AW)) bus ();
    vxc_mul3_sequencer_if #(.NO_OF_UNITS(NU), .ELEMENT_WIDTH(EW), .ADDR_WIDTH(AW)) bus16 ();

    vxc_mul3_sequencer #(
        .NUM_EQ(19), .NO_OF_UNITS(NU), .ELEMENT_WIDTH(EW), .DP_LATENCY(DPL), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .constant(constant),
        .rd_base(rd_base), .wr_base(wr_base), .busy(busy), .done(done), .bus(bus)
    );

    vxc_mul3_sequencer #(
        .NUM_EQ(16), .NO_OF_UNITS(NU), .ELEMENT_WIDTH(EW), .DP_LATENCY(DPL), .ADDR_WIDTH(AW)
    ) dut16 (
        .clk(clk), .reset(reset), .start(start16), .op(op), .constant(constant),
        .rd_base(rd_base), .wr_base(wr_base), .busy(busy16), .done(done16), .bus(bus16)
    );

    function automatic logic [63:0] lane_calc(input logic [63:0] a, input logic [63:0] b,
                                              input logic [63:0] c, input logic o);
        logic [31:0] re;
        logic [31:0] im;
        re = a[63:32] * c[63:32] - a[31:0] * c[31:0];
        im = a[63:32] * c[31:0] + a[31:0] * c[63:32];
        if (o) begin
            re = re - b[63:32];
            im = im - b[31:0];
        end else begin
            re = re + b[63:32];
            im = im + b[31:0];
        end
        return {re, im};
    endfunction

    function automatic logic [CW-1:0] chunk_calc(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                                 input logic [63:0] c, input logic o);
        logic [CW-1:0] r;
        r = '0;
        for (int l = 0; l < NU; l++) begin
            r[l*64 +: 64] = lane_calc(a[l*64 +: 64], b[l*64 +: 64], c, o);
        end
        return r;
    endfunction

    // Combinational operand memory and a fixed-latency model of the datapath.
    assign bus.rd_data_a   = mem_a[bus.rd_addr];
    assign bus.rd_data_b   = mem_b[bus.rd_addr];
    assign bus.dp_result   = dp_pipe[DPL-1];
    assign bus16.rd_data_a = mem_a[bus16.rd_addr];
    assign bus16.rd_data_b = mem_b[bus16.rd_addr];
    assign bus16.dp_result = '0;

    always @(posedge clk) begin
        dp_pipe[0] <= chunk_calc(bus.dp_a, bus.dp_b, bus.dp_constant, bus.dp_op);
        for (int i = 1; i < DPL; i++) begin
            dp_pipe[i] <= dp_pipe[i-1];
        end
    end

    typedef struct packed {
        logic [7:0]    addr;
        logic [7:0]    lanes;
        logic [CW-1:0] data;
    } wr_txn_t;

    wr_txn_t sb_q [$];

    typedef struct {
        logic [7:0]      rb;
        logic [7:0]      wb;
        logic            o;
        logic [63:0]     c;
        logic [2:0][7:0] exp_rd;
        logic [2:0][7:0] exp_wr;
        logic [7:0]      exp_last_lane;
    } vec_t;

    vec_t vecs [4];

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_wide(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_expected(input logic [7:0] rb, input logic [7:0] wb,
                                 input logic o, input logic [63:0] c);
        wr_txn_t    t;
        logic [7:0] ra;
        for (int k = 0; k < TB_CHUNKS; k++) begin
            ra      = rb + 8'(k);
            t.addr  = wb + 8'(k);
            t.lanes = (k == TB_CHUNKS - 1) ? TB_LAST_LANE : 8'hFF;
            t.data  = chunk_calc(mem_a[ra], mem_b[ra], c, o);
            sb_q.push_back(t);
        end
    endtask

    // Scoreboard: every write must match the next expected transaction, and done implies drained.
    always @(negedge clk) begin
        wr_txn_t t;
        if (bus.wr_en === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL sb_unexpected_write: got write at %0h expected none", bus.wr_addr);
            end else begin
                t = sb_q.pop_front();
                check_output("sb_wr_addr", 64'(bus.wr_addr), 64'(t.addr));
                check_output("sb_wr_lane_en", 64'(bus.wr_lane_en), 64'(t.lanes));
                check_wide("sb_wr_data", bus.wr_data, t.data);
            end
        end
        if (done === 1'b1) begin
            check_output("sb_drained_at_done", 64'(sb_q.size()), 64'd0);
        end
    end

    task automatic apply_stimulus(input int vi);
        logic          c_rd_en [12];
        logic [7:0]    c_rd_addr [12];
        logic          c_dpv [12];
        logic          c_wr_en [12];
        logic [7:0]    c_wr_addr [12];
        logic [7:0]    c_lane [12];
        logic          c_done [12];
        logic          c_busy [12];
        logic          c_dp_op [12];
        logic [63:0]   c_dp_const [12];
        vec_t v;
        v = vecs[vi];
        @(negedge clk);
        op       = v.o;
        constant = v.c;
        rd_base  = v.rb;
        wr_base  = v.wb;
        start    = 1'b1;
        push_expected(v.rb, v.wb, v.o, v.c);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            c_rd_en[k]    = bus.rd_en;
            c_rd_addr[k]  = bus.rd_addr;
            c_dpv[k]      = bus.dp_valid_in;
            c_wr_en[k]    = bus.wr_en;
            c_wr_addr[k]  = bus.wr_addr;
            c_lane[k]     = bus.wr_lane_en;
            c_done[k]     = done;
            c_busy[k]     = busy;
            c_dp_op[k]    = bus.dp_op;
            c_dp_const[k] = bus.dp_constant;
            start    = 1'b0;
            op       = ~op;
            constant = {$urandom(), $urandom()};
            rd_base  = 8'($urandom());
            wr_base  = 8'($urandom());
        end
        for (int k = 1; k <= 11; k++) begin
            check_output($sformatf("v%0d_c%0d_rd_en", vi, k), 64'(c_rd_en[k]), 64'(k >= 1 && k <= 3));
            if (k <= 3) begin
                check_output($sformatf("v%0d_c%0d_rd_addr", vi, k), 64'(c_rd_addr[k]), 64'(v.exp_rd[k-1]));
            end
            check_output($sformatf("v%0d_c%0d_dp_valid_in", vi, k), 64'(c_dpv[k]), 64'(k >= 2 && k <= 4));
            check_output($sformatf("v%0d_c%0d_wr_en", vi, k), 64'(c_wr_en[k]), 64'(k >= 5 && k <= 7));
            if (k >= 5 && k <= 7) begin
                check_output($sformatf("v%0d_c%0d_wr_addr", vi, k), 64'(c_wr_addr[k]), 64'(v.exp_wr[k-5]));
                check_output($sformatf("v%0d_c%0d_wr_lane_en", vi, k), 64'(c_lane[k]),
                             64'((k == 7) ? v.exp_last_lane : 8'hFF));
            end else begin
                check_output($sformatf("v%0d_c%0d_wr_lane_en", vi, k), 64'(c_lane[k]), 64'd0);
            end
            check_output($sformatf("v%0d_c%0d_done", vi, k), 64'(c_done[k]), 64'(k == 8));
            check_output($sformatf("v%0d_c%0d_busy", vi, k), 64'(c_busy[k]), 64'(k <= 8));
            if (k == 4) begin
                check_output($sformatf("v%0d_dp_op", vi), 64'(c_dp_op[k]), 64'(v.o));
                check_output($sformatf("v%0d_dp_constant", vi), c_dp_const[k], v.c);
            end
        end
    endtask

    task automatic check_all_idle(input string tag);
        check_output({tag, "_busy"}, 64'(busy), 64'd0);
        check_output({tag, "_done"}, 64'(done), 64'd0);
        check_output({tag, "_rd_en"}, 64'(bus.rd_en), 64'd0);
        check_output({tag, "_rd_addr"}, 64'(bus.rd_addr), 64'd0);
        check_output({tag, "_dp_valid_in"}, 64'(bus.dp_valid_in), 64'd0);
        check_output({tag, "_dp_a_zero"}, 64'(bus.dp_a == '0 && bus.dp_b == '0), 64'd1);
        check_output({tag, "_dp_op"}, 64'(bus.dp_op), 64'd0);
        check_output({tag, "_dp_constant"}, bus.dp_constant, 64'd0);
        check_output({tag, "_wr_en"}, 64'(bus.wr_en), 64'd0);
        check_output({tag, "_wr_addr"}, 64'(bus.wr_addr), 64'd0);
        check_output({tag, "_wr_lane_en"}, 64'(bus.wr_lane_en), 64'd0);
    endtask

    task automatic reset_mid_operation();
        int done_at;
        @(negedge clk);
        op = vecs[0].o; constant = vecs[0].c; rd_base = vecs[0].rb; wr_base = vecs[0].wb;
        start = 1'b1;
        push_expected(vecs[0].rb, vecs[0].wb, vecs[0].o, vecs[0].c);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check_output("rst_pre_wr_en", 64'(bus.wr_en), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_all_idle("rst_c7");
        sb_q.delete();
        @(negedge clk);
        check_output("rst_c8_wr_en", 64'(bus.wr_en), 64'd0);
        check_output("rst_c8_done", 64'(done), 64'd0);
        @(negedge clk);
        op = vecs[1].o; constant = vecs[1].c; rd_base = vecs[1].rb; wr_base = vecs[1].wb;
        start = 1'b1;
        push_expected(vecs[1].rb, vecs[1].wb, vecs[1].o, vecs[1].c);
        done_at = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1 && done_at < 0) done_at = k;
        end
        check_output("rst_restart_done_cycle", 64'(done_at), 64'd8);
    endtask

    task automatic back_to_back();
        logic b_done [21];
        logic b_busy [21];
        @(negedge clk);
        op = vecs[2].o; constant = vecs[2].c; rd_base = vecs[2].rb; wr_base = vecs[2].wb;
        start = 1'b1;
        push_expected(vecs[2].rb, vecs[2].wb, vecs[2].o, vecs[2].c);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            b_done[k] = done;
            b_busy[k] = busy;
            if (k == 9) push_expected(vecs[2].rb, vecs[2].wb, vecs[2].o, vecs[2].c);
            if (k == 10) start = 1'b0;
        end
        for (int k = 1; k <= 20; k++) begin
            check_output($sformatf("b2b_c%0d_done", k), 64'(b_done[k]), 64'(k == 8 || k == 17));
            check_output($sformatf("b2b_c%0d_busy", k), 64'(b_busy[k]),
                         64'(k <= 8 || (k >= 10 && k <= 17)));
        end
    endtask

    task automatic no_tail_instance();
        logic [7:0] lanes [$];
        int done_at;
        done_at = -1;
        @(negedge clk);
        start16 = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            start16 = 1'b0;
            if (bus16.wr_en === 1'b1) lanes.push_back(bus16.wr_lane_en);
            if (done16 === 1'b1 && done_at < 0) done_at = k;
        end
        check_output("n16_write_count", 64'(lanes.size()), 64'd2);
        for (int i = 0; i < lanes.size(); i++) begin
            check_output($sformatf("n16_w%0d_lane_en", i), 64'(lanes[i]), 64'hFF);
        end
        check_output("n16_done_cycle", 64'(done_at), 64'd7);
        check_output("n16_busy_after", 64'(busy16), 64'd0);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        start16  = 1'b0;
        op       = 1'b0;
        constant = '0;
        rd_base  = '0;
        wr_base  = '0;
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = {16{$urandom()}};
            mem_b[i] = {16{$urandom()}};
        end

        vecs[0].rb = 8'h10; vecs[0].wb = 8'h40; vecs[0].o = 1'b0; vecs[0].c = 64'h00000003_00000002;
        vecs[0].exp_rd = {8'h12, 8'h11, 8'h10}; vecs[0].exp_wr = {8'h42, 8'h41, 8'h40};
        vecs[0].exp_last_lane = 8'h07;
        vecs[1].rb = 8'h20; vecs[1].wb = 8'h60; vecs[1].o = 1'b1; vecs[1].c = 64'hFFFFFFFE_00000005;
        vecs[1].exp_rd = {8'h22, 8'h21, 8'h20}; vecs[1].exp_wr = {8'h62, 8'h61, 8'h60};
        vecs[1].exp_last_lane = 8'h07;
        vecs[2].rb = 8'hFE; vecs[2].wb = 8'hFF; vecs[2].o = 1'b0; vecs[2].c = 64'h12345678_9ABCDEF0;
        vecs[2].exp_rd = {8'h00, 8'hFF, 8'hFE}; vecs[2].exp_wr = {8'h01, 8'h00, 8'hFF};
        vecs[2].exp_last_lane = 8'h07;
        vecs[3].rb = 8'h7F; vecs[3].wb = 8'h80; vecs[3].o = 1'b1; vecs[3].c = 64'h00000001_00000000;
        vecs[3].exp_rd = {8'h81, 8'h80, 8'h7F}; vecs[3].exp_wr = {8'h82, 8'h81, 8'h80};
        vecs[3].exp_last_lane = 8'h07;

        repeat (3) @(negedge clk);
        check_all_idle("reset");
        check_output("reset_busy16", 64'(busy16), 64'd0);
        reset = 1'b0;

        for (int vi = 0; vi < 4; vi++) begin
            apply_stimulus(vi);
        end
        reset_mid_operation();
        back_to_back();
        no_tail_instance();

        repeat (2) @(negedge clk);
        check_output("sb_final_empty", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vxc_mul3_sequencer.md
Name: vxc_mul3_sequencer

Overview:
Sequences the conjugate vector-times-constant-plus-vector datapath over a full cluster. It fetches two operand vectors from a banked operand memory, one NO_OF_UNITS-lane chunk per cycle, and presents each chunk pair to the datapath. It then writes the datapath results to the result memory with per-lane write enables. It replaces counter-based free-running feeding with a start/done handshake and uses exact latency tracking.

Parameters:
NUM_EQ, 19, equations per cluster (vector length)
NO_OF_UNITS, 8, lanes per chunk
ELEMENT_WIDTH, 64, bits per complex element (32 re / 32 im)
DP_LATENCY, 3, datapath cycles from dp_valid_in to dp_result valid; must be >= 1
ADDR_WIDTH, 8, chunk address width for the operand and result memories

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  launch request; sampled only in IDLE
op  in  1  add/sub select; latched at start
constant  in  ELEMENT_WIDTH  complex scalar; latched at start
rd_base  in  ADDR_WIDTH  first operand chunk address; latched at start
wr_base  in  ADDR_WIDTH  first result chunk address; latched at start
busy  out  1  high from the cycle after start is accepted through the done cycle
done  out  1  one-cycle completion pulse
rd_en  out  1  operand memory read strobe (memory read latency is 1 cycle)
rd_addr  out  ADDR_WIDTH  operand chunk address
rd_data_a  in  NO_OF_UNITS*ELEMENT_WIDTH  first-row chunk
rd_data_b  in  NO_OF_UNITS*ELEMENT_WIDTH  second-row chunk
dp_a, dp_b  out  NO_OF_UNITS*ELEMENT_WIDTH  datapath operands
dp_constant  out  ELEMENT_WIDTH  latched constant
dp_op  out  1  latched op
dp_valid_in  out  1  operand chunk valid
dp_result  in  NO_OF_UNITS*ELEMENT_WIDTH  datapath output
wr_en  out  1  result memory write strobe
wr_addr  out  ADDR_WIDTH  result chunk address
wr_data  out  NO_OF_UNITS*ELEMENT_WIDTH  dp_result, passed through combinationally
wr_lane_en  out  NO_OF_UNITS  per-lane write enable

Behaviour:
- NUM_CHUNKS = ceil(NUM_EQ/NO_OF_UNITS), which is 3 at the defaults. TAIL = NUM_EQ mod NO_OF_UNITS.
- Reset values: busy=0, done=0, rd_en=0, rd_addr=0, dp_valid_in=0, dp_a=0, dp_b=0, dp_op=0, dp_constant=0, wr_en=0, wr_addr=0, wr_lane_en=0. The FSM returns to IDLE.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE: on start=1 at cycle 0, latch op, constant, rd_base and wr_base, clear the chunk counter, and go to READ.
- READ: cycles 1..NUM_CHUNKS.
  - rd_en=1, with rd_addr = rd_base + k, where k is the chunk index.
  - After the last chunk, go to DRAIN.
- Registered operand stage: dp_a/dp_b <= rd_data_a/rd_data_b one cycle after each rd_en, with dp_valid_in=1 that cycle. This gives dp_valid_in on cycles 2..NUM_CHUNKS+1.
- Delay line: a DP_LATENCY-deep shift register carries {valid, chunk index}.
  - wr_en is asserted on cycles 2+DP_LATENCY .. NUM_CHUNKS+1+DP_LATENCY.
  - wr_addr = wr_base + chunk index.
- DRAIN: wait until the delay line is empty, i.e. the last write has issued, then go to DONE.
- DONE: done=1 for one cycle (cycle NUM_CHUNKS+2+DP_LATENCY), then return to IDLE. busy falls together with done.
- wr_lane_en: all ones, except on the last chunk when TAIL≠0. In that case bits [TAIL-1:0] are 1 and the rest are 0.
- Address arithmetic: modulo 2^ADDR_WIDTH; wrap-around is permitted and silent.
- start while busy, or in the DONE cycle: ignored. A new start is accepted only in IDLE, so the earliest restart is the cycle after done.
- Latched op/constant stay stable for the whole operation; input changes during busy have no effect.
- Reset mid-operation: on the next edge, clear the FSM, the delay line and all strobes. No further wr_en and no done pulse are produced.
- dp_result is consumed only when wr_en=1. The sequencer has no backpressure; the datapath and memories are fixed-latency.

Decomposition:
- Shared package vxc_seq_pkg holds:
  - the clog2 function;
  - the derived constants NUM_CHUNKS and TAIL;
  - the state encoding localparams (IDLE=0, READ=1, DRAIN=2, DONE=3).
- One sub-module: vxc_seq_delay_line. It is a parameterised DEPTH × (1+ADDR_WIDTH) shift register with synchronous clear, used for the write-side valid and index alignment.

Test Plan:
- Defaults, rd_base=8'h10, wr_base=8'h40, start at cycle 0 -> rd_en on cycles 1-3 at 10,11,12; dp_valid_in on cycles 2-4; wr_en on cycles 5-7 at 40,41,42; done on cycle 8 only; busy high on cycles 1-8.
- Tail mask, NUM_EQ=19 -> wr_lane_en=8'hFF on the first two writes and 8'h07 on the third. With NUM_EQ=16 -> two writes, both 8'hFF.
- Data integrity: the datapath model returns a*constant±b. Write memory contents must match the golden model for op=0 and op=1, with op toggled on the input during busy and no effect observed.
- Wrap-around: rd_base=8'hFE, wr_base=8'hFF -> rd_addr sequence FE,FF,00 and wr_addr sequence FF,00,01.
- Reset at cycle 6 -> no wr_en and no done from cycle 7 on. All outputs are 0, and a start at cycle 9 runs a full clean sequence.
- start held high continuously -> back-to-back operations: the second is accepted on cycle 9, and done pulses on cycles 8 and 17.
